// File: rtl/uart_tx.sv
// 8-bit UART transmitter with built-in 16x oversample baud divider (8N1 by default).
// Define UART_TX_PARITY_EN for an even-parity bit between D7 and STOP (8E1).
`timescale 1ns/1ps

module uart_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tick
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W    = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_div_chk
    $error("uart_tx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if (OVERSAMPLE != 16) begin : g_os_chk
    $error("uart_tx: OVERSAMPLE must be 16 to match uart_rx");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]       r_tick_cnt, w_tick_cnt_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy;
  logic             r_tick;
  logic             w_tick;
  logic             w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_tick    = (r_div == DIV_LAST);
  assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);

  // Next-state, counters and next line level
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = w_tick ? '0 : r_div + DIV_W'(1);
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_done_nxt     = 1'b0;
    w_txd_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_nxt      = r_par;
`endif

    if ((r_state != S_IDLE) && w_tick) begin
      w_tick_cnt_nxt = r_tick_cnt + 4'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_state_nxt    = S_START;
          w_shreg_nxt    = data_in;
          w_div_nxt      = '0;
          w_tick_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
`ifdef UART_TX_PARITY_EN
          w_par_nxt      = ^data_in;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shreg_nxt   = r_shreg >> 1;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level follows the state being entered so txd itself stays a flop
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = w_par_nxt;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tick     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      r_tick     <= (w_div_nxt == DIV_LAST);
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign txd     = r_txd;
  assign tx_busy = r_busy;
  assign tx_done = r_done;
  assign tick    = r_tick;

endmodule
